// File: rtl/meas_counter.sv
// Cycle counter with armed capture, 2^AVG_LOG2 averaging and a
// single-entry valid/ready result register with SAT/OVERRUN flags.
//
// Ports:
//   clock    : system clock, rising edge
//   RST_N    : async active-low reset
//   CLK_EN   : count enable from timing controller
//   RESET    : measurement clear (counter clear + arm)
//   OUT_COMP : one-cycle capture pulse
//   READY    : consumer accepts DATA when VALID && READY
//   CLR_OVR  : clears OVERRUN (a same-edge set wins)
//   CNT      : live counter value
//   DATA     : averaged result
//   SAT      : result contains a saturated capture
//   VALID    : DATA/SAT hold a result
//   OVERRUN  : sticky, a result was dropped
module meas_counter #(
  parameter int CNT_W    = 24,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clock,
  input  logic             RST_N,
  input  logic             CLK_EN,
  input  logic             RESET,
  input  logic             OUT_COMP,
  input  logic             READY,
  input  logic             CLR_OVR,
  output logic [CNT_W-1:0] CNT,
  output logic [CNT_W-1:0] DATA,
  output logic             SAT,
  output logic             VALID,
  output logic             OVERRUN
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'((1 << AVG_LOG2) - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             armed_q, armed_d;
  logic             wsat_q, wsat_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic             sat_q, sat_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             cap;
  logic             last;
  logic             smp_sat;
  logic             push;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] res;

  assign cap     = OUT_COMP && armed_q;
  assign last    = (idx_q == LAST);
  assign smp_sat = (cnt_q == {CNT_W{1'b1}});
  assign push    = cap && last;
  // Sample is the pre-update counter; accumulator is wide enough
  // that the final sum never overflows.
  assign sum     = acc_q + ACC_W'(cnt_q);
  assign res     = CNT_W'(sum >> AVG_LOG2);

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    armed_d = armed_q;
    wsat_d  = wsat_q;
    data_d  = data_q;
    sat_d   = sat_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (RESET) begin
      cnt_d = '0;
    end else if (CLK_EN && !smp_sat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // RESET re-arms even when it coincides with a capture.
    if (RESET) begin
      armed_d = 1'b1;
    end else if (cap) begin
      armed_d = 1'b0;
    end

    if (cap) begin
      if (last) begin
        acc_d  = '0;
        idx_d  = '0;
        wsat_d = 1'b0;
      end else begin
        acc_d  = sum;
        idx_d  = idx_q + IDX_W'(1);
        wsat_d = wsat_q | smp_sat;
      end
    end

    if (CLR_OVR) begin
      ovr_d = 1'b0;
    end

    if (push) begin
      if (!valid_q || READY) begin
        data_d  = res;
        sat_d   = wsat_q | smp_sat;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && READY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      armed_q <= 1'b0;
      wsat_q  <= 1'b0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      armed_q <= armed_d;
      wsat_q  <= wsat_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign CNT     = cnt_q;
  assign DATA    = data_q;
  assign SAT     = sat_q;
  assign VALID   = valid_q;
  assign OVERRUN = ovr_q;

endmodule

// File: doc/meas_counter.md
Name: meas_counter

Overview:
- Downstream consumer of the capacitor-timing controller.
- Counts clock cycles while CLK_EN is high and clears on the controller's RESET.
- Captures the count on each OUT_COMP pulse and averages 2^AVG_LOG2 captures.
- Presents each averaged result on a valid/ready output with saturation and overrun flags, for the readout/register stage.

Parameters:
- CNT_W, 24, width of the cycle counter and of DATA.
- AVG_LOG2, 2, log2 of the number of captures averaged per result (0 = pass-through, every capture is a result).

Ports:
- clock  in  1  system clock, all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- CLK_EN  in  1  count enable from timing controller
- RESET  in  1  measurement clear from timing controller (active high)
- OUT_COMP  in  1  one-cycle capture pulse from timing controller
- READY  in  1  consumer accepts DATA when VALID&&READY at a clock edge
- CLR_OVR  in  1  clears OVERRUN
- CNT  out  CNT_W  live counter value (debug)
- DATA  out  CNT_W  averaged result
- SAT  out  1  result contains at least one saturated capture
- VALID  out  1  DATA/SAT hold a result
- OVERRUN  out  1  sticky: a result was dropped

Behaviour:
- Reset (RST_N=0, async): all registers cleared, including counter, accumulator, capture index, armed flag and window-saturation flag. Outputs CNT=0, DATA=0, SAT=0, VALID=0, OVERRUN=0.
- Counter priority per edge:
  - RESET=1: CNT<=0.
  - Else CLK_EN=1: CNT<=CNT+1, saturating at all-ones (no wrap).
  - Else: hold.
- Armed flag:
  - Set on any edge with RESET=1.
  - Cleared on an accepted capture.
  - OUT_COMP while not armed is ignored: no accumulation, no flags. This includes the first pulse after RST_N if no RESET has been seen.
- Capture, on an edge with OUT_COMP=1 and armed=1:
  - Sample = CNT register value before that edge's update, i.e. the pre-increment value if CLK_EN is also 1.
  - If OUT_COMP and RESET are both 1, the capture uses the pre-clear value and armed stays set, because RESET's set wins.
- Accumulation:
  - Accumulator width is CNT_W+AVG_LOG2, so it cannot overflow.
  - The capture index counts 0..2^AVG_LOG2-1.
  - Window-saturation flag |= (sample == all-ones).
  - On a capture with index < 2^AVG_LOG2-1: acc+=sample, index++.
  - On a capture with index == 2^AVG_LOG2-1: the result is (acc+sample)>>AVG_LOG2 (truncating), with SAT = window flag | this sample's saturation. Then acc, index and window flag are cleared and the result is pushed.
  - AVG_LOG2=0: every accepted capture pushes the sample unchanged.
- Output register (single entry):
  - Push with VALID=0 → VALID=1 and DATA/SAT loaded on the same edge. VALID rises one cycle after the OUT_COMP cycle.
  - Push with VALID=1 and READY=1 → new result loaded, VALID stays 1 (back-to-back).
  - Push with VALID=1 and READY=0 → new result dropped, OVERRUN<=1, and DATA/SAT keep their held values.
  - No push with VALID&&READY → VALID<=0. DATA keeps its last value.
  - DATA and SAT must not change while VALID=1 and READY=0.
- OVERRUN:
  - Sticky.
  - Cleared by CLR_OVR=1.
  - If a set condition and CLR_OVR occur on the same edge, set wins.
- RESET does not affect the accumulator, the index or the output register. Only RST_N does.
- Async RST_N assertion mid-window discards the partial average. The first result after release needs a full 2^AVG_LOG2 fresh captures.

Test Plan:
1. CNT_W=8, AVG_LOG2=0; RESET 1 cycle, CLK_EN 100 cycles, OUT_COMP pulse with CLK_EN=0, READY=1 → VALID pulses 1 cycle after the OUT_COMP cycle, DATA=100, SAT=0.
2. AVG_LOG2=2; four measurements of 10, 11, 12, 14 cycles (RESET before each), READY=1 → exactly one result, DATA=11 (47>>2), no VALID after the first three captures.
3. CNT_W=8; CLK_EN held 300 cycles then OUT_COMP → CNT sticks at 255, DATA=255 (AVG_LOG2=0), SAT=1. With AVG_LOG2=2 and captures 255, 10, 10, 10 → DATA=71, SAT=1.
4. AVG_LOG2=0, READY=0; two measurements (DATA 20, then 30) → DATA stays 20, OVERRUN=1. Raise READY → VALID drops after one cycle. Pulse CLR_OVR → OVERRUN=0. Next capture with CLR_OVR and a dropped push on the same edge → OVERRUN remains 1.
5. After RST_N release, OUT_COMP without a prior RESET → ignored (VALID stays 0). OUT_COMP a second time without an intervening RESET → ignored.
6. AVG_LOG2=2; two captures, then assert RST_N low mid-count → all outputs 0 immediately (async). After release, four fresh captures of 8 → DATA=8. Also capture with CLK_EN=1 at CNT=5 → sample 5, not 6.
